bus_hold_arbiter: RTL and testbench
===================================

// Module: bus_hold_arbiter
// PURPOSE
//  Shares the 8088 local bus between the CPU and NREQ DMA-style requesters.
//  Uses the CPU HOLD/HLDA handshake and picks requesters round-robin.
//  Grants the bus to one requester at a time as a bounded burst.
//  Sits beside the CPU in the system top; HOLD drives the CPU HOLD pin and
//  HLDA comes from the CPU HLDA pin.
// PARAMETERS
//  NREQ          2   number of bus requesters (1..8)
//  MAX_BURST     16  max BUS_CYCLE pulses per grant before forced release
//  HLDA_TIMEOUT  64  cycles in REQ_HOLD without HLDA before abort
// PORTS
//  CLK          in   1     system clock; all logic on posedge
//  RESET        in   1     synchronous, active-low reset
//  DREQ         in   NREQ  level request per requester
//  BUS_CYCLE    in   1     1-cycle pulse from the active requester per completed transfer
//  HLDA         in   1     CPU hold acknowledge
//  HOLD         out  1     hold request to CPU (registered)
//  DACK         out  NREQ  one-hot grant; at most one bit set (registered)
//  BUSY         out  1     1 in any state other than IDLE
//  TIMEOUT_ERR  out  1     sticky: HLDA never arrived within HLDA_TIMEOUT
//  PROTO_ERR    out  1     sticky: HLDA dropped while DACK asserted
// BEHAVIOUR
//  Reset (RESET==0 at posedge), including mid-operation:
//   - next state is IDLE; HOLD, DACK, BUSY, TIMEOUT_ERR and PROTO_ERR are 0.
//   - rr pointer is 0; burst and timeout counters are 0.
//  IDLE:
//   - if |DREQ, latch winner = first set bit at or after rr pointer (wrapping).
//   - go to REQ_HOLD; HOLD=1 one cycle after DREQ is sampled.
//  REQ_HOLD:
//   - HOLD=1; timeout counter increments each cycle.
//   - HLDA==1: go to GRANT; DACK[winner]=1 on the next edge.
//     HLDA sampled at edge m gives DACK at m+1.
//   - DREQ[winner] drops first: HOLD=0, go to RELEASE.
//   - counter reaches HLDA_TIMEOUT-1 without HLDA: TIMEOUT_ERR=1, HOLD=0;
//     rr pointer = winner+1 mod NREQ; go to IDLE.
//  GRANT:
//   - HOLD=1 and DACK[winner]=1.
//   - burst counter ($clog2(MAX_BURST+1) bits) increments on BUS_CYCLE; it
//     saturates and never wraps.
//   - exit when DREQ[winner]==0, or when the count reaches MAX_BURST (the
//     BUS_CYCLE that hits MAX_BURST counts).
//   - on exit, next edge: DACK=0, HOLD=0; rr pointer = winner+1 mod NREQ;
//     go to RELEASE.
//   - HLDA==0 while in GRANT: DACK=0 and HOLD=0 next edge, PROTO_ERR=1,
//     go to RELEASE.
//  RELEASE:
//   - HOLD=0; stay until HLDA==0, then go to IDLE.
//   - RELEASE lasts at least 1 cycle, so HOLD has a low gap of at least 2
//     cycles between grants.
//  Other rules:
//   - no preemption: other DREQs during GRANT wait.
//   - a re-request by the same winner is served only after all others in
//     rr order.
//   - BUS_CYCLE outside GRANT is ignored.
//   - TIMEOUT_ERR and PROTO_ERR clear only on reset.
// STRUCTURE
//  - bus_arb_pkg holds: typedef enum logic [1:0] {IDLE, REQ_HOLD, GRANT,
//    RELEASE} arb_state_t, and default constants for MAX_BURST and
//    HLDA_TIMEOUT.
//  - Sub-module rr_pick #(NREQ): combinational; inputs req and ptr, outputs
//    one-hot gnt and valid. One instance.
//  - FSM, counters and output registers live in bus_hold_arbiter.
// TESTING
//  1. DREQ=2'b01 at cycle 0; HLDA rises 3 cycles after HOLD.
//     -> HOLD=1 at cycle 1, DACK=01 one cycle after HLDA.
//  2. Hold DREQ=01 and give 16 BUS_CYCLE pulses.
//     -> DACK=0 and HOLD=0 on the edge after the 16th pulse;
//        RELEASE until HLDA=0.
//  3. DREQ=2'b11 held continuously; each grant ends via MAX_BURST.
//     -> DACK sequence 01,10,01,10 with no back-to-back repeat.
//  4. HLDA tied 0, DREQ=01.
//     -> HOLD falls after 64 cycles, TIMEOUT_ERR=1, BUSY=0, DACK never set.
//  5. In GRANT, drop HLDA for 1 cycle.
//     -> DACK=0 next edge, PROTO_ERR=1, FSM waits in RELEASE.
//  6. RESET=0 for 1 cycle mid-GRANT.
//     -> next edge HOLD=0, DACK=0, errors=0, state IDLE, rr pointer=0.

Source files
------------

// File: rtl/bus_arb_pkg.sv
// Shared types and default limits for the 8088 HOLD/HLDA bus arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ_HOLD = 2'd1,
    GRANT    = 2'd2,
    RELEASE  = 2'd3
  } arb_state_t;

  localparam int DEF_MAX_BURST    = 16;
  localparam int DEF_HLDA_TIMEOUT = 64;

  // Next requester index after idx, wrapping at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic            valid
);

  int          sum;
  logic [PW-1:0] idx;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    sum   = 0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = int'(ptr) + k;
      if (sum >= NREQ) sum = sum - NREQ;
      idx = PW'(sum);
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_hold_arbiter.sv
// Shares the CPU local bus with NREQ requesters via HOLD/HLDA, round-robin, bounded bursts.
// HOLD follows DREQ by one cycle; DACK follows sampled HLDA by one cycle.
module bus_hold_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NREQ         = 2,
  parameter int MAX_BURST    = DEF_MAX_BURST,
  parameter int HLDA_TIMEOUT = DEF_HLDA_TIMEOUT
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [NREQ-1:0] DREQ,
  input  logic            BUS_CYCLE,
  input  logic            HLDA,
  output logic            HOLD,
  output logic [NREQ-1:0] DACK,
  output logic            BUSY,
  output logic            TIMEOUT_ERR,
  output logic            PROTO_ERR
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = (HLDA_TIMEOUT > 1) ? $clog2(HLDA_TIMEOUT) : 1;

  arb_state_t      state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win_q, win_d;
  logic [BW-1:0]   burst_q, burst_d, burst_nx;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            hold_q, hold_d;
  logic [NREQ-1:0] dack_q, dack_d;
  logic            terr_q, terr_d;
  logic            perr_q, perr_d;

  logic [NREQ-1:0] pick_gnt;
  logic            pick_vld;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   win_inc;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (DREQ),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .valid (pick_vld)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) pick_idx = PW'(i);
    end
  end

  assign win_inc = PW'(wrap_inc(int'(win_q), NREQ));

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    burst_d  = burst_q;
    tmo_d    = tmo_q;
    hold_d   = hold_q;
    dack_d   = dack_q;
    terr_d   = terr_q;
    perr_d   = perr_q;
    // Saturating count; the pulse that reaches MAX_BURST ends the grant.
    burst_nx = burst_q;
    if (BUS_CYCLE && burst_q != BW'(MAX_BURST)) burst_nx = burst_q + BW'(1);

    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          win_d   = pick_idx;
          tmo_d   = '0;
          hold_d  = 1'b1;
          state_d = REQ_HOLD;
        end
      end
      REQ_HOLD: begin
        if (HLDA) begin
          dack_d  = NREQ'(1) << win_q;
          burst_d = '0;
          state_d = GRANT;
        end else if (!DREQ[win_q]) begin
          hold_d  = 1'b0;
          state_d = RELEASE;
        end else if (tmo_q == TW'(HLDA_TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          hold_d  = 1'b0;
          ptr_d   = win_inc;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      GRANT: begin
        if (!HLDA) begin
          perr_d  = 1'b1;
          hold_d  = 1'b0;
          dack_d  = '0;
          ptr_d   = win_inc;
          state_d = RELEASE;
        end else begin
          burst_d = burst_nx;
          if (!DREQ[win_q] || burst_nx == BW'(MAX_BURST)) begin
            hold_d  = 1'b0;
            dack_d  = '0;
            ptr_d   = win_inc;
            state_d = RELEASE;
          end
        end
      end
      RELEASE: begin
        if (!HLDA) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      win_q   <= '0;
      burst_q <= '0;
      tmo_q   <= '0;
      hold_q  <= 1'b0;
      dack_q  <= '0;
      terr_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      burst_q <= burst_d;
      tmo_q   <= tmo_d;
      hold_q  <= hold_d;
      dack_q  <= dack_d;
      terr_q  <= terr_d;
      perr_q  <= perr_d;
    end
  end

  assign HOLD        = hold_q;
  assign DACK        = dack_q;
  assign BUSY        = (state_q != IDLE);
  assign TIMEOUT_ERR = terr_q;
  assign PROTO_ERR   = perr_q;

endmodule

// File: tb/tb_bus_hold_arbiter.sv
// Directed scenarios plus randomized DREQ/HLDA/BUS_CYCLE traffic against a behavioural bus-ownership model.
module tb_bus_hold_arbiter;

  localparam int N  = 2;
  localparam int MB = 16;
  localparam int TO = 64;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic [N-1:0] DREQ = '0;
  logic         BUS_CYCLE = 1'b0;
  logic         HLDA = 1'b0;
  logic         HOLD, BUSY, TIMEOUT_ERR, PROTO_ERR;
  logic [N-1:0] DACK;

  bus_hold_arbiter #(.NREQ(N), .MAX_BURST(MB), .HLDA_TIMEOUT(TO)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .DREQ        (DREQ),
    .BUS_CYCLE   (BUS_CYCLE),
    .HLDA        (HLDA),
    .HOLD        (HOLD),
    .DACK        (DACK),
    .BUSY        (BUSY),
    .TIMEOUT_ERR (TIMEOUT_ERR),
    .PROTO_ERR   (PROTO_ERR)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Behavioural model: who owns the bus, who is waiting for HLDA, who is next in line.
  int m_rr = 0;      // requester that gets first look at the next arbitration
  int m_cand = -1;   // requester HOLD was raised for, waiting on HLDA
  int m_own = -1;    // requester currently acknowledged
  int m_wait = 0;    // cycles spent waiting for HLDA
  int m_xfers = 0;   // transfers completed by the current owner
  bit m_hold = 0;
  bit m_rel = 0;     // bus handed back, waiting for CPU to drop HLDA
  bit m_terr = 0;
  bit m_perr = 0;

  function automatic bit req_bit(input int i);
    logic [N-1:0] t;
    t = DREQ >> i;
    return t[0];
  endfunction

  task automatic model_end_grant();
    m_rr   = (m_own + 1) % N;
    m_own  = -1;
    m_cand = -1;
    m_hold = 0;
    m_rel  = 1;
  endtask

  always @(posedge CLK) begin
    if (!RESET) begin
      m_rr = 0; m_cand = -1; m_own = -1; m_wait = 0; m_xfers = 0;
      m_hold = 0; m_rel = 0; m_terr = 0; m_perr = 0;
    end else if (m_rel) begin
      if (!HLDA) m_rel = 0;
    end else if (m_own >= 0) begin
      if (!HLDA) begin
        m_perr = 1;
        model_end_grant();
      end else begin
        if (BUS_CYCLE && m_xfers < MB) m_xfers++;
        if (!req_bit(m_own) || m_xfers == MB) model_end_grant();
      end
    end else if (m_hold) begin
      if (HLDA) begin
        m_own = m_cand;
        m_xfers = 0;
      end else if (!req_bit(m_cand)) begin
        m_hold = 0; m_rel = 1; m_cand = -1;
      end else if (m_wait == TO - 1) begin
        m_terr = 1; m_hold = 0;
        m_rr = (m_cand + 1) % N;
        m_cand = -1;
      end else begin
        m_wait++;
      end
    end else if (DREQ != '0) begin
      for (int k = N - 1; k >= 0; k--)
        if (req_bit((m_rr + k) % N)) m_cand = (m_rr + k) % N;
      m_hold = 1;
      m_wait = 0;
    end
  end

  // Advance one clock, then compare every output with the model.
  task automatic tick();
    logic [N-1:0] d;
    @(posedge CLK);
    #1;
    d = '0;
    if (m_own >= 0) d = N'(1) << m_own;
    check("model", 32'({HOLD, DACK, BUSY, TIMEOUT_ERR, PROTO_ERR}),
          32'({m_hold, d, m_hold | m_rel, m_terr, m_perr}));
  endtask

  task automatic reset_dut();
    RESET = 1'b0; DREQ = '0; HLDA = 1'b0; BUS_CYCLE = 1'b0;
    tick();
    tick();
    RESET = 1'b1;
  endtask

  initial begin
    logic [N-1:0] prev;
    logic [N-1:0] seq[4];
    int got;
    int n;
    bit seen;
    bit hold_prev;
    int dly;

    // Reset state and first grant timing
    reset_dut();
    check("reset_outs", 32'({HOLD, DACK, BUSY, TIMEOUT_ERR, PROTO_ERR}), 0);
    DREQ = 2'b01;
    tick();
    check("t1_hold", 32'(HOLD), 1);
    check("t1_busy", 32'(BUSY), 1);
    tick(); tick(); tick();
    check("t1_dack_pre", 32'(DACK), 0);
    HLDA = 1'b1;
    tick();
    check("t1_dack", 32'(DACK), 1);

    // Burst limit of MB transfers
    BUS_CYCLE = 1'b1;
    repeat (MB - 1) tick();
    check("t2_dack_pre", 32'(DACK), 1);
    tick();
    BUS_CYCLE = 1'b0;
    check("t2_dack", 32'(DACK), 0);
    check("t2_hold", 32'(HOLD), 0);
    check("t2_busy", 32'(BUSY), 1);
    DREQ = '0;
    tick();
    check("t2_release", 32'(BUSY), 1);
    HLDA = 1'b0;
    tick();
    check("t2_idle", 32'(BUSY), 0);

    // Both requesting continuously: grants alternate
    reset_dut();
    DREQ = 2'b11; BUS_CYCLE = 1'b1;
    prev = '0; got = 0;
    for (int c = 0; c < 400 && got < 4; c++) begin
      tick();
      HLDA = HOLD;
      if (DACK != '0 && prev == '0) begin
        seq[got] = DACK;
        got++;
      end
      prev = DACK;
    end
    check("t3_grants", 32'(got), 4);
    for (int i = 0; i < got; i++) check("t3_seq", 32'(seq[i]), (i % 2 == 0) ? 32'd1 : 32'd2);
    DREQ = '0; BUS_CYCLE = 1'b0;

    // HLDA never comes
    reset_dut();
    DREQ = 2'b01;
    tick();
    n = 0; seen = 0;
    for (int c = 0; c < 200 && HOLD; c++) begin
      n++;
      if (DACK != '0) seen = 1;
      tick();
    end
    check("t4_hold_cycles", 32'(n), TO);
    check("t4_terr", 32'(TIMEOUT_ERR), 1);
    check("t4_busy", 32'(BUSY), 0);
    check("t4_no_dack", 32'(seen), 0);
    DREQ = '0;
    tick();
    check("t4_terr_sticky", 32'(TIMEOUT_ERR), 1);

    // HLDA drops during a grant
    reset_dut();
    DREQ = 2'b01;
    tick();
    HLDA = 1'b1;
    tick();
    check("t5_dack", 32'(DACK), 1);
    tick();
    HLDA = 1'b0;
    tick();
    check("t5_dack_off", 32'(DACK), 0);
    check("t5_hold_off", 32'(HOLD), 0);
    check("t5_perr", 32'(PROTO_ERR), 1);
    check("t5_busy", 32'(BUSY), 1);
    HLDA = 1'b1;
    tick(); tick();
    check("t5_wait", 32'(BUSY), 1);
    DREQ = '0; HLDA = 1'b0;
    tick();
    check("t5_idle", 32'(BUSY), 0);

    // Reset in the middle of a grant to requester 1
    DREQ = 2'b10;
    tick();
    HLDA = 1'b1;
    tick();
    check("t6_dack", 32'(DACK), 2);
    BUS_CYCLE = 1'b1;
    tick(); tick();
    RESET = 1'b0; BUS_CYCLE = 1'b0;
    tick();
    check("t6_reset_outs", 32'({HOLD, DACK, BUSY, TIMEOUT_ERR, PROTO_ERR}), 0);
    RESET = 1'b1; HLDA = 1'b0; DREQ = 2'b11;
    tick();
    HLDA = 1'b1;
    tick();
    check("t6_rr_zero", 32'(DACK), 1);
    DREQ = '0;
    tick();
    HLDA = 1'b0;
    tick();

    // Randomized traffic with a CPU that answers HOLD after a random delay
    reset_dut();
    hold_prev = 0; dly = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 15) == 0) DREQ = DREQ ^ (N'(1) << b);
      BUS_CYCLE = ($urandom_range(0, 1) == 1);
      if (HOLD && !hold_prev) dly = ($urandom_range(0, 19) == 0) ? 70 : int'($urandom_range(0, 3));
      if (!HOLD && hold_prev) dly = int'($urandom_range(0, 2));
      hold_prev = HOLD;
      if (HOLD != HLDA) begin
        if (dly == 0) HLDA = HOLD;
        else dly--;
      end else if (HLDA && $urandom_range(0, 199) == 0) begin
        HLDA = 1'b0;
      end
      RESET = ($urandom_range(0, 599) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
